// File: rtl/time_set_ctrl.sv
// HH:MM time-setting sequencer: RUN -> SET_HOUR -> SET_MIN -> commit, with field blink and abort.
// Optional feature: define AUTO_REPEAT_EN for held-button auto-repeat increments.
module time_set_ctrl #(
  parameter int BLINK_PERIOD  = 25_000_000,
  parameter int BLINK_OFF     = 5_500_000,
  parameter int TIMEOUT_CYC   = 250_000_000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 5_000_000
`endif
) (
  input  logic       uclock,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       switch,
  input  logic       switch2,
  input  logic [3:0] cur_num0,
  input  logic [3:0] cur_num1,
  input  logic [3:0] cur_num2,
  input  logic [3:0] cur_num3,
  output logic [3:0] set_num0,
  output logic [3:0] set_num1,
  output logic [3:0] set_num2,
  output logic [3:0] set_num3,
  output logic       load,
  output logic       setting,
  output logic [3:0] disp_num0,
  output logic [3:0] disp_num1,
  output logic [3:0] disp_num2,
  output logic [3:0] disp_num3
);

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_t;

  localparam int BW = $clog2(BLINK_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t      state, state_nx;
  logic [15:0] shadow, shadow_nx;
  logic [2:0]  mode_sync, inc_sync;
  logic [BW-1:0] blink;
  logic [TW-1:0] idle_cnt;
  logic        mode_edge, inc_edge, rpt_tick, inc_evt, in_set, timed_out;
  logic        entry, bump, commit, blank;

  assign mode_edge = mode_sync[1] & ~mode_sync[2];
  assign inc_edge  = inc_sync[1] & ~inc_sync[2];
  assign in_set    = (state != RUN);
  assign setting   = in_set;
  assign inc_evt   = in_set & (inc_edge | rpt_tick);
  assign timed_out = (idle_cnt == TW'(TIMEOUT_CYC - 1));
  assign blank     = (blink < BW'(BLINK_OFF));

  // Out-of-range fields (including illegal captures) fold to 00
  function automatic logic [7:0] next_hours(input logic [7:0] h);
    if (h[7:4] > 4'd2 || h[3:0] > 4'd9 || (h[7:4] == 4'd2 && h[3:0] >= 4'd3))
      return 8'h00;
    else if (h[3:0] == 4'd9)
      return {h[7:4] + 4'd1, 4'd0};
    else
      return {h[7:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] next_mins(input logic [7:0] m);
    if (m[7:4] > 4'd5 || m[3:0] > 4'd9 || (m[7:4] == 4'd5 && m[3:0] == 4'd9))
      return 8'h00;
    else if (m[3:0] == 4'd9)
      return {m[7:4] + 4'd1, 4'd0};
    else
      return {m[7:4], m[3:0] + 4'd1};
  endfunction

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rpt_cnt;

  assign rpt_tick = in_set & inc_sync[1] & inc_sync[2] & (rpt_cnt == RW'(REPEAT_DELAY));

  // After the first repeat, reload so later ticks fall every REPEAT_PERIOD cycles
  always_ff @(posedge uclock or negedge rst_n) begin
    if (!rst_n)                    rpt_cnt <= '0;
    else if (!(in_set && inc_sync[1])) rpt_cnt <= '0;
    else if (rpt_tick)             rpt_cnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    else                           rpt_cnt <= rpt_cnt + 1'b1;
  end
`else
  assign rpt_tick = 1'b0;
`endif

  // Abort beats mode, mode beats increment
  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    entry     = 1'b0;
    bump      = 1'b0;
    commit    = 1'b0;
    case (state)
      RUN: begin
        if (mode_edge && !switch && !switch2) begin
          state_nx  = SET_HOUR;
          shadow_nx = {cur_num3, cur_num2, cur_num1, cur_num0};
          entry     = 1'b1;
        end
      end
      SET_HOUR: begin
        if (switch || switch2 || timed_out) begin
          state_nx = RUN;
        end else if (mode_edge) begin
          state_nx = SET_MIN;
          entry    = 1'b1;
        end else if (inc_evt) begin
          shadow_nx[15:8] = next_hours(shadow[15:8]);
          bump            = 1'b1;
        end
      end
      SET_MIN: begin
        if (switch || switch2 || timed_out) begin
          state_nx = RUN;
        end else if (mode_edge) begin
          state_nx = RUN;
          commit   = 1'b1;
        end else if (inc_evt) begin
          shadow_nx[7:0] = next_mins(shadow[7:0]);
          bump           = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge uclock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      shadow    <= '0;
      mode_sync <= '0;
      inc_sync  <= '0;
      idle_cnt  <= '0;
      blink     <= '0;
    end else begin
      state     <= state_nx;
      shadow    <= shadow_nx;
      mode_sync <= {mode_sync[1:0], mode_btn};
      inc_sync  <= {inc_sync[1:0], inc_btn};
      if (!in_set || mode_edge || inc_evt) idle_cnt <= '0;
      else                                 idle_cnt <= idle_cnt + 1'b1;
      if (entry)                                blink <= '0;
      else if (bump)                            blink <= BW'(BLINK_OFF);
      else if (blink == BW'(BLINK_PERIOD - 1))  blink <= '0;
      else                                      blink <= blink + 1'b1;
    end
  end

  // Registered outputs: commit strobe, committed value and display digits
  always_ff @(posedge uclock or negedge rst_n) begin
    if (!rst_n) begin
      load      <= 1'b0;
      {set_num3, set_num2, set_num1, set_num0}     <= '0;
      {disp_num3, disp_num2, disp_num1, disp_num0} <= '0;
    end else begin
      load <= commit;
      if (commit) {set_num3, set_num2, set_num1, set_num0} <= shadow;
      case (state)
        SET_HOUR: {disp_num3, disp_num2, disp_num1, disp_num0} <=
                    {(blank ? 8'hAA : shadow[15:8]), shadow[7:0]};
        SET_MIN:  {disp_num3, disp_num2, disp_num1, disp_num0} <=
                    {shadow[15:8], (blank ? 8'hAA : shadow[7:0])};
        default:  {disp_num3, disp_num2, disp_num1, disp_num0} <=
                    {cur_num3, cur_num2, cur_num1, cur_num0};
      endcase
    end
  end

endmodule
